sram_bus_arbiter: RTL and testbench

Parametrised N-master to 1-slave arbiter for the core's req/addr_ok/data_ok SRAM-style memory interface. It lets the instruction-fetch port, the data port and any future masters (DMA, debug) share a single memory port with multiple outstanding transactions. It selects a master per address phase using fixed-priority or round-robin arbitration. It records the owner of each accepted request in an in-order ID FIFO and routes each returning data_ok and rdata to that owner. It sits between the core's iram/dram ports and the unified memory or bus bridge.

---
 rtl/sram_bus_arbiter.sv | 146 ++++++++++++++
 tb/tb_sram_bus_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/sram_bus_arbiter.sv
// N-master to 1-slave arbiter for the req/addr_ok/data_ok SRAM-style interface.
// Address phase is granted by fixed priority or round robin; responses are routed in order via an ID FIFO.
module sram_bus_arbiter #(
  parameter int unsigned NUM_MST         = 2,
  parameter int unsigned XLEN            = 32,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned ARB_MODE        = 0
) (
  input  logic                          clk,
  input  logic                          rst_b,
  input  logic [NUM_MST-1:0]            m_req,
  input  logic [NUM_MST-1:0]            m_write,
  input  logic [NUM_MST*(XLEN/8)-1:0]   m_wstrb,
  input  logic [NUM_MST*XLEN-1:0]       m_addr,
  input  logic [NUM_MST*XLEN-1:0]       m_wdata,
  output logic [NUM_MST-1:0]            m_addr_ok,
  output logic [NUM_MST-1:0]            m_data_ok,
  output logic [NUM_MST*XLEN-1:0]       m_rdata,
  output logic                          s_req,
  output logic                          s_write,
  output logic [XLEN/8-1:0]             s_wstrb,
  output logic [XLEN-1:0]               s_addr,
  output logic [XLEN-1:0]               s_wdata,
  input  logic                          s_addr_ok,
  input  logic                          s_data_ok,
  input  logic [XLEN-1:0]               s_rdata,
  output logic                          err_unexp_data
);

  localparam int unsigned IDW  = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;
  localparam int unsigned PTRW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CNTW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned SW   = XLEN / 8;

  logic            lock;
  logic [IDW-1:0]  lock_id;
  logic [IDW-1:0]  rr_ptr;
  logic [IDW-1:0]  win;
  logic [IDW-1:0]  cand;
  logic            found;
  logic [IDW-1:0]  grant;
  logic            sel_req;
  logic            hs;
  logic            pop;
  logic            full;
  logic            empty;
  logic [IDW-1:0]  head;

  logic [IDW-1:0]  fifo_mem [MAX_OUTSTANDING];
  logic [PTRW-1:0] wr_ptr;
  logic [PTRW-1:0] rd_ptr;
  logic [CNTW-1:0] count;

  // Winner search: starts at rr_ptr in round-robin mode, at master 0 otherwise.
  always_comb begin
    win   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < int'(NUM_MST); k++) begin
      if (ARB_MODE == 1)
        cand = IDW'((int'(rr_ptr) + k) % int'(NUM_MST));
      else
        cand = IDW'(k);
      if (!found && m_req[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
    grant = lock ? lock_id : win;
  end

  // Payload mux toward the slave.
  always_comb begin
    sel_req = 1'b0;
    s_write = 1'b0;
    s_wstrb = '0;
    s_addr  = '0;
    s_wdata = '0;
    for (int i = 0; i < int'(NUM_MST); i++) begin
      if (grant == IDW'(i)) begin
        sel_req = m_req[i];
        s_write = m_write[i];
        s_wstrb = m_wstrb[i*SW +: SW];
        s_addr  = m_addr[i*XLEN +: XLEN];
        s_wdata = m_wdata[i*XLEN +: XLEN];
      end
    end
  end

  assign full  = (count == CNTW'(MAX_OUTSTANDING));
  assign empty = (count == '0);
  // Full blocks issue from registered state only, so s_data_ok never reaches s_req.
  assign s_req = sel_req & ~full;
  assign hs    = s_req & s_addr_ok;
  assign pop   = s_data_ok & ~empty;
  assign head  = fifo_mem[rd_ptr];

  always_comb begin
    m_addr_ok = '0;
    m_data_ok = '0;
    for (int i = 0; i < int'(NUM_MST); i++) begin
      m_addr_ok[i] = hs  && (grant == IDW'(i));
      m_data_ok[i] = pop && (head  == IDW'(i));
    end
  end

  assign m_rdata = {NUM_MST{s_rdata}};

  // ID storage carries no reset; entries are only read while count is non-zero.
  always_ff @(posedge clk) begin
    if (hs)
      fifo_mem[wr_ptr] <= grant;
  end

  // Lock, round-robin pointer, FIFO bookkeeping and sticky error flag.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      lock           <= 1'b0;
      lock_id        <= '0;
      rr_ptr         <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      err_unexp_data <= 1'b0;
    end else begin
      if (hs) begin
        lock   <= 1'b0;
        rr_ptr <= (grant == IDW'(NUM_MST - 1)) ? '0 : grant + IDW'(1);
        wr_ptr <= (wr_ptr == PTRW'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr + PTRW'(1);
      end else if (s_req && !s_addr_ok) begin
        lock    <= 1'b1;
        lock_id <= grant;
      end
      if (pop)
        rd_ptr <= (rd_ptr == PTRW'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr + PTRW'(1);
      case ({hs, pop})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: count <= count;
      endcase
      if (s_data_ok && empty)
        err_unexp_data <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed bench for sram_bus_arbiter: a fixed-priority 2-master instance (depth 2)
// and a round-robin 3-master instance (depth 4), checked against hand-computed values.
module tb_sram_bus_arbiter;

  logic clk = 1'b0;
  logic rst_b;
  always #5 clk = ~clk;

  // Fixed-priority instance
  logic [1:0]  f_m_req, f_m_write, f_m_addr_ok, f_m_data_ok;
  logic [7:0]  f_m_wstrb;
  logic [63:0] f_m_addr, f_m_wdata, f_m_rdata;
  logic        f_s_req, f_s_write, f_s_addr_ok, f_s_data_ok, f_err;
  logic [3:0]  f_s_wstrb;
  logic [31:0] f_s_addr, f_s_wdata, f_s_rdata;

  // Round-robin instance
  logic [2:0]  r_m_req, r_m_write, r_m_addr_ok, r_m_data_ok;
  logic [11:0] r_m_wstrb;
  logic [95:0] r_m_addr, r_m_wdata, r_m_rdata;
  logic        r_s_req, r_s_write, r_s_addr_ok, r_s_data_ok, r_err;
  logic [3:0]  r_s_wstrb;
  logic [31:0] r_s_addr, r_s_wdata, r_s_rdata;

  sram_bus_arbiter #(.NUM_MST(2), .XLEN(32), .MAX_OUTSTANDING(2), .ARB_MODE(0)) u_fix (
    .clk(clk), .rst_b(rst_b),
    .m_req(f_m_req), .m_write(f_m_write), .m_wstrb(f_m_wstrb), .m_addr(f_m_addr), .m_wdata(f_m_wdata),
    .m_addr_ok(f_m_addr_ok), .m_data_ok(f_m_data_ok), .m_rdata(f_m_rdata),
    .s_req(f_s_req), .s_write(f_s_write), .s_wstrb(f_s_wstrb), .s_addr(f_s_addr), .s_wdata(f_s_wdata),
    .s_addr_ok(f_s_addr_ok), .s_data_ok(f_s_data_ok), .s_rdata(f_s_rdata),
    .err_unexp_data(f_err)
  );

  sram_bus_arbiter #(.NUM_MST(3), .XLEN(32), .MAX_OUTSTANDING(4), .ARB_MODE(1)) u_rr (
    .clk(clk), .rst_b(rst_b),
    .m_req(r_m_req), .m_write(r_m_write), .m_wstrb(r_m_wstrb), .m_addr(r_m_addr), .m_wdata(r_m_wdata),
    .m_addr_ok(r_m_addr_ok), .m_data_ok(r_m_data_ok), .m_rdata(r_m_rdata),
    .s_req(r_s_req), .s_write(r_s_write), .s_wstrb(r_s_wstrb), .s_addr(r_s_addr), .s_wdata(r_s_wdata),
    .s_addr_ok(r_s_addr_ok), .s_data_ok(r_s_data_ok), .s_rdata(r_s_rdata),
    .err_unexp_data(r_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns later.
  task automatic nxt();
    @(negedge clk);
  endtask

  logic [2:0]  rr_exp   [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
  logic [2:0]  mix_req  [4] = '{3'b001, 3'b010, 3'b010, 3'b001};
  int          mix_own  [4] = '{0, 1, 1, 0};
  logic [31:0] mix_data [4] = '{32'hA, 32'hB, 32'hC, 32'hD};
  logic [31:0] slice;

  initial begin
    rst_b = 1'b0;
    f_m_req = '0; f_m_write = 2'b10; f_m_wstrb = {4'hC, 4'hF};
    f_m_addr = {32'h200, 32'h100}; f_m_wdata = {32'hBBBB0001, 32'hAAAA0000};
    f_s_addr_ok = 1'b0; f_s_data_ok = 1'b0; f_s_rdata = '0;
    r_m_req = '0; r_m_write = '0; r_m_wstrb = '1;
    r_m_addr = {32'h3000, 32'h2000, 32'h1000}; r_m_wdata = '0;
    r_s_addr_ok = 1'b0; r_s_data_ok = 1'b0; r_s_rdata = '0;

    // Reset state
    nxt(); nxt(); #1;
    check("rst_err_f", 64'(f_err), 64'd0);
    check("rst_err_r", 64'(r_err), 64'd0);
    check("rst_addr_ok", 64'(f_m_addr_ok), 64'd0);
    check("rst_data_ok", 64'(f_m_data_ok), 64'd0);
    nxt(); rst_b = 1'b1;

    // Fixed priority: master 0 always wins, master 1 starved
    nxt(); f_m_req = 2'b11; f_s_addr_ok = 1'b1; #1;
    check("fix_addr_ok_c1", 64'(f_m_addr_ok), 64'b01);
    check("fix_s_addr_c1", 64'(f_s_addr), 64'h100);
    for (int c = 0; c < 2; c++) begin
      nxt(); f_s_data_ok = 1'b1; f_s_rdata = 32'(32'h11 * (c + 1)); #1;
      check("fix_addr_ok_pp", 64'(f_m_addr_ok), 64'b01);
      check("fix_data_ok_pp", 64'(f_m_data_ok), 64'b01);
      check("fix_rdata_pp", 64'(f_m_rdata[31:0]), 64'(32'h11 * (c + 1)));
    end
    nxt(); f_m_req = 2'b00; #1;
    check("fix_drain_data_ok", 64'(f_m_data_ok), 64'b01);
    check("fix_drain_s_req", 64'(f_s_req), 64'd0);

    // Lock hold: master 1 waits 3 cycles, master 0 arrives in cycle 2
    nxt(); f_m_req = 2'b10; f_s_addr_ok = 1'b0; f_s_data_ok = 1'b0; #1;
    check("lock_s_req_c1", 64'(f_s_req), 64'd1);
    check("lock_s_addr_c1", 64'(f_s_addr), 64'h200);
    check("lock_addr_ok_c1", 64'(f_m_addr_ok), 64'd0);
    nxt(); f_m_req = 2'b11; #1;
    check("lock_s_addr_c2", 64'(f_s_addr), 64'h200);
    check("lock_s_write_c2", 64'(f_s_write), 64'd1);
    check("lock_s_wstrb_c2", 64'(f_s_wstrb), 64'hC);
    check("lock_addr_ok_c2", 64'(f_m_addr_ok), 64'd0);
    nxt(); #1;
    check("lock_s_addr_c3", 64'(f_s_addr), 64'h200);
    check("lock_s_wdata_c3", 64'(f_s_wdata), 64'hBBBB0001);
    nxt(); f_s_addr_ok = 1'b1; #1;
    check("lock_hs_addr_ok", 64'(f_m_addr_ok), 64'b10);
    check("lock_hs_s_addr", 64'(f_s_addr), 64'h200);
    nxt(); f_m_req = 2'b01; #1;
    check("lock_after_addr_ok", 64'(f_m_addr_ok), 64'b01);
    check("lock_after_s_addr", 64'(f_s_addr), 64'h100);

    // Full FIFO (depth 2): issue blocked until a slot frees on the previous edge
    nxt(); #1;
    check("full_s_req", 64'(f_s_req), 64'd0);
    check("full_addr_ok", 64'(f_m_addr_ok), 64'd0);
    nxt(); f_s_data_ok = 1'b1; f_s_rdata = 32'h55; #1;
    check("full_pop_data_ok", 64'(f_m_data_ok), 64'b10);
    check("full_pop_s_req", 64'(f_s_req), 64'd0);
    nxt(); f_s_data_ok = 1'b0; #1;
    check("full_reissue_s_req", 64'(f_s_req), 64'd1);
    check("full_reissue_addr_ok", 64'(f_m_addr_ok), 64'b01);
    nxt(); f_m_req = 2'b00; f_s_data_ok = 1'b1; #1;
    check("full_drain1", 64'(f_m_data_ok), 64'b01);
    nxt(); #1;
    check("full_drain2", 64'(f_m_data_ok), 64'b01);

    // Unexpected data_ok with empty FIFO
    nxt(); #1;
    check("err_no_data_ok", 64'(f_m_data_ok), 64'd0);
    nxt(); f_s_data_ok = 1'b0; #1;
    check("err_set", 64'(f_err), 64'd1);
    nxt(); f_m_req = 2'b01; #1;
    check("err_accept_pre_rst", 64'(f_m_addr_ok), 64'b01);
    nxt(); f_m_req = 2'b00; #1;
    check("err_sticky", 64'(f_err), 64'd1);

    // Round robin: all three requesting, grants 0,1,2,0
    for (int c = 0; c < 4; c++) begin
      nxt(); r_m_req = 3'b111; r_s_addr_ok = 1'b1; #1;
      check("rr_grant", 64'(r_m_addr_ok), 64'(rr_exp[c]));
      if (c == 1) check("rr_s_addr_m1", 64'(r_s_addr), 64'h2000);
    end
    nxt(); #1;
    check("rr_full_s_req", 64'(r_s_req), 64'd0);
    for (int c = 0; c < 4; c++) begin
      nxt(); r_m_req = 3'b000; r_s_data_ok = 1'b1; r_s_rdata = 32'(c + 1); #1;
      check("rr_resp", 64'(r_m_data_ok), 64'(rr_exp[c]));
    end

    // Mixed owners M0,M1,M1,M0 then in-order responses
    for (int c = 0; c < 4; c++) begin
      nxt(); r_m_req = mix_req[c]; r_s_data_ok = 1'b0; #1;
      check("mix_accept", 64'(r_m_addr_ok), 64'(mix_req[c]));
    end
    for (int c = 0; c < 4; c++) begin
      nxt(); r_m_req = 3'b000; r_s_data_ok = 1'b1; r_s_rdata = mix_data[c]; #1;
      check("mix_data_ok", 64'(r_m_data_ok), 64'(mix_req[c]));
      slice = r_m_rdata[mix_own[c]*32 +: 32];
      check("mix_rdata", 64'(slice), 64'(mix_data[c]));
    end

    // Asynchronous reset mid-operation (fixed instance has one outstanding)
    nxt(); r_s_data_ok = 1'b0; rst_b = 1'b0; #1;
    check("rst_async_err", 64'(f_err), 64'd0);
    nxt(); rst_b = 1'b1;
    nxt(); f_s_data_ok = 1'b1; r_m_req = 3'b111; r_s_addr_ok = 1'b1; #1;
    check("post_rst_no_data_ok", 64'(f_m_data_ok), 64'd0);
    check("post_rst_rr_ptr0", 64'(r_m_addr_ok), 64'b001);
    nxt(); f_s_data_ok = 1'b0; r_m_req = 3'b000; f_m_req = 2'b11; f_s_addr_ok = 1'b1; #1;
    check("post_rst_err_again", 64'(f_err), 64'd1);
    check("post_rst_acc1", 64'(f_m_addr_ok), 64'b01);
    nxt(); #1;
    check("post_rst_acc2", 64'(f_m_addr_ok), 64'b01);
    nxt(); #1;
    check("post_rst_full", 64'(f_s_req), 64'd0);
    nxt(); f_m_req = 2'b00;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
